// File: rtl/lector_memoria_pixeles_pkg.sv
// Shared definitions for the pixel-memory reader and its pixel buffer.
//   - state_t            : sequencer state enumeration
//   - LECTOR_ADDR_WIDTH  : default word-address / word-count width
//   - LECTOR_DATA_WIDTH  : default memory word width (one 4-pixel word)
//   - PIXELS_PER_WORD    : pixels packed per memory word, shared with buffer_pixeles_mem
package lector_pkg;

    localparam int unsigned LECTOR_ADDR_WIDTH = 18;
    localparam int unsigned LECTOR_DATA_WIDTH = 32;
    localparam int unsigned PIXELS_PER_WORD   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_REQUEST,
        ST_WAIT_DATA,
        ST_PUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lector_memoria_pixeles_if.sv
// Pixel-memory read port.
//   master : sequencer side (drives mem_read/mem_addr, receives data)
//   slave  : memory side   (receives the read, returns mem_data_valid/mem_data)
interface lector_memoria_pixeles_if
    import lector_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LECTOR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LECTOR_DATA_WIDTH
);

    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_data_valid;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_data_valid,
        input  mem_data
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_data_valid,
        output mem_data
    );

endinterface

// File: rtl/lector_memoria_pixeles.sv
// Sequencer that copies a contiguous region of pixel-memory words into
// buffer_pixeles_mem, one word at a time with at most one read outstanding.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a transfer (sampled only in IDLE)
//   base_addr         : first word address, captured with start
//   num_words         : number of words, captured with start
//   mem               : memory read port (master modport)
//   space_available   : buffer can accept one more word
//   save_mem_data     : one-cycle write strobe to the buffer
//   memory_data       : word presented to the buffer
//   busy              : high outside IDLE
//   done              : one-cycle pulse after the last word is pushed
// Build option: LECTOR_LOOP_EN restarts the captured region after every pass.
module lector_memoria_pixeles
    import lector_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LECTOR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LECTOR_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  num_words,
    lector_memoria_pixeles_if.master mem,
    input  logic                   space_available,
    output logic                   save_mem_data,
    output logic [DATA_WIDTH-1:0]  memory_data,
    output logic                   busy,
    output logic                   done
);

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  mem_read_q, mem_read_n;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;
    logic                  save_q, save_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
`ifdef LECTOR_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [ADDR_WIDTH-1:0] count_q, count_n;
`endif

    // Next state, counters and the next value of every registered output.
    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        remaining_n = remaining_q;
        data_n      = data_q;
`ifdef LECTOR_LOOP_EN
        base_n      = base_q;
        count_n     = count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef LECTOR_LOOP_EN
                    base_n  = base_addr;
                    count_n = num_words;
`endif
                    if (num_words != '0) begin
                        addr_n      = base_addr;
                        remaining_n = num_words;
                        state_n     = ST_WAIT_SPACE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (space_available) state_n = ST_REQUEST;
            end
            ST_REQUEST: begin
                state_n = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (mem.mem_data_valid) begin
                    data_n  = mem.mem_data;
                    state_n = ST_PUSH;
                end
            end
            ST_PUSH: begin
                addr_n      = addr_q + ADDR_WIDTH'(1);
                remaining_n = remaining_q - ADDR_WIDTH'(1);
                state_n     = (remaining_q == ADDR_WIDTH'(1)) ? ST_DONE : ST_WAIT_SPACE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
`ifdef LECTOR_LOOP_EN
                // An empty region would never make progress, so it stops instead of looping.
                if (count_q != '0) begin
                    addr_n      = base_q;
                    remaining_n = count_q;
                    state_n     = ST_WAIT_SPACE;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        mem_read_n = (state_n == ST_REQUEST);
        mem_addr_n = (state_n == ST_REQUEST) ? addr_n : mem_addr_q;
        save_n     = (state_n == ST_PUSH);
        done_n     = (state_n == ST_DONE);
        busy_n     = (state_n != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            save_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LECTOR_LOOP_EN
            base_q      <= '0;
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            remaining_q <= remaining_n;
            data_q      <= data_n;
            mem_read_q  <= mem_read_n;
            mem_addr_q  <= mem_addr_n;
            save_q      <= save_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
`ifdef LECTOR_LOOP_EN
            base_q      <= base_n;
            count_q     <= count_n;
`endif
        end
    end

    assign mem.mem_read  = mem_read_q;
    assign mem.mem_addr  = mem_addr_q;
    assign save_mem_data = save_q;
    assign memory_data   = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/lector_memoria_pixeles.md
# lector_memoria_pixeles

Sequencer feeding `buffer_pixeles_mem`: on `start` it reads a contiguous region of 32-bit words from pixel memory and pushes each word into the pixel buffer with a one-cycle `save_mem_data` strobe. It issues a read only when the buffer reports `space_available`. It keeps at most one memory read outstanding, so the buffer can never overflow.

## Interface
- `ADDR_WIDTH`, 18, word-address width of pixel memory and of the word count
- `DATA_WIDTH`, 32, memory word width; fixed to the buffer's 4-pixel word
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first word address; captured with `start`
- `num_words`  in  ADDR_WIDTH  words to transfer; captured with `start`
- `mem_read`  out  1  read strobe to memory, high exactly one cycle per word
- `mem_addr`  out  ADDR_WIDTH  address valid while `mem_read`=1
- `mem_data_valid`  in  1  memory returns `mem_data` this cycle; earliest one cycle after `mem_read`
- `mem_data`  in  DATA_WIDTH  read data
- `space_available`  in  1  from buffer: one more word can be accepted
- `save_mem_data`  out  1  write strobe to buffer
- `memory_data`  out  DATA_WIDTH  word to buffer; valid while `save_mem_data`=1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the last word of a transfer is pushed

## Operation
- States: IDLE, WAIT_SPACE, REQUEST, WAIT_DATA, PUSH, DONE.
- IDLE:
  - `start` with `num_words`≠0 loads `addr`=`base_addr` and `remaining`=`num_words`, then goes to WAIT_SPACE.
  - `start` with `num_words`=0 goes to DONE directly. No memory access occurs.
- WAIT_SPACE: waits until `space_available`=1, then goes to REQUEST.
- REQUEST: `mem_read`=1 and `mem_addr`=`addr`, then goes to WAIT_DATA unconditionally.
- WAIT_DATA: holds until `mem_data_valid`=1, latches `mem_data` into the output register, then goes to PUSH. There is no timeout.
- PUSH:
  - `save_mem_data`=1; `addr` increments and `remaining` decrements.
  - If `remaining` was 1, go to DONE; otherwise go to WAIT_SPACE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `addr` wraps modulo 2^ADDR_WIDTH. `remaining` never underflows.
- `start` outside IDLE is ignored. `mem_data_valid` outside WAIT_DATA is ignored.
- All outputs are decoded from registered state, so no output depends combinationally on an input.

## Timing
- Reset values:
  - state=IDLE.
  - `mem_read`, `save_mem_data`, `busy`, `done` = 0.
  - `mem_addr` = 0, `memory_data` = 0, internal counters = 0.
- `start` sampled at edge 0: WAIT_SPACE at cycle 1. If `space_available`=1, `mem_read` is high in cycle 2.
- `mem_data_valid` in cycle N gives `save_mem_data` in cycle N+1.
- Minimum 4 cycles per word, achieved with 1-cycle memory latency and space always available.
- `done` rises the cycle after the last `save_mem_data`. `busy` falls the cycle after `done`.
- `space_available` is sampled only in WAIT_SPACE. A buffer that becomes full during REQUEST or WAIT_DATA cannot occur, because this block is the buffer's only writer.
- Reset mid-transfer returns to IDLE on the next edge. A late `mem_data_valid` from an aborted read is ignored, and no `save_mem_data` is issued for it.

## Configuration
- `LECTOR_LOOP_EN` defined:
  - DONE still pulses `done`, but then reloads `addr`=`base_addr` and `remaining`=`num_words` (the captured values) and goes to WAIT_SPACE instead of IDLE. This streams frames continuously until `reset`.
  - `busy` stays high throughout.
- `LECTOR_LOOP_EN` undefined: the behaviour above; one transfer per `start`.

## Structure
- Shared package `lector_pkg`:
  - state enumeration
  - default `ADDR_WIDTH`/`DATA_WIDTH`
  - `PIXELS_PER_WORD`=4, shared with `buffer_pixeles_mem`
- Single module; no sub-module needed. The address counter and word counter live inline.

## Test plan
- Reset, then `start` with `base_addr`=0x00010, `num_words`=3, memory latency 1, `space_available`=1.
  - Required: `mem_addr` 0x10, 0x11, 0x12.
  - Required: `save_mem_data` with 0xaabbccdd, 0xabcdef77, 0x12345678 every 4 cycles.
  - Required: `done` one cycle after the third push.
- Hold `space_available`=0 for 10 cycles after `start`. Required: no `mem_read` in those cycles; first `mem_read` the cycle after `space_available` rises.
- Memory latency 5 cycles. Required: `save_mem_data` exactly 1 cycle after each `mem_data_valid`; `mem_read` never has two reads outstanding.
- `num_words`=0. Required: `done` pulse at cycle 1, no `mem_read`, `busy` high one cycle only.
- `base_addr`=0x3FFFF, `num_words`=2. Required: addresses 0x3FFFF then 0x00000.
- `reset` asserted in WAIT_DATA, then `mem_data_valid` arrives.
  - Required: IDLE, no `save_mem_data`.
  - Required: a new `start` works normally.
  - With `LECTOR_LOOP_EN`: `done` pulses after each 3-word pass, and addresses restart at 0x10.
